// File: rtl/data_memory.sv
// Word-addressed 32-bit data memory with combinational read, clocked write and
// preload-on-reset (word[i] = i). Define DATA_MEMORY_BOUNDS_CHECK_EN to reject out-of-range addresses.
module data_memory #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] index;
  logic          in_range;
  logic          unused_bits;

  assign index = address[AW+1:2];

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  assign in_range    = ~|address[31:AW+2];
  assign unused_bits = ^address[1:0];
`else
  // Upper bits are dropped so the address space wraps modulo DEPTH words.
  assign in_range    = 1'b1;
  assign unused_bits = ^{address[31:AW+2], address[1:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'(i);
      end
    end else if (write && in_range) begin
      mem[index] <= write_data;
    end
  end

  always_comb begin
    read_data = 32'h0000_0000;
    if (in_range) begin
      read_data = mem[index];
    end
  end

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && write && !in_range) begin
      $display("data_memory warning: out-of-range write discarded, address=%h", address);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, reset sequence,
// and randomized traffic against an array-based reference model.
module tb_data_memory;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int checks;
  int errors;

  logic [31:0] model [DEPTH];

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_before;
    logic [31:0] exp_after;
  } vec_t;

  vec_t vecs[$];

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write      (write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    write      = wr;
    address    = addr;
    write_data = wd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp);
    checks++;
    if (read_data !== exp) begin
      errors++;
      $display("[TB] FAIL %s: read_data=%h expected=%h (address=%h)", name, read_data, exp, address);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] addr);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    return (addr / 32'(DEPTH * 4)) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int model_index(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (!model_in_range(addr)) return 32'h0;
    return model[model_index(addr)];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = i;
  endtask

  // Drives one operation at the falling edge and checks both sides of the next rising edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    applyStimulus(v.wr, v.addr, v.wdata);
    #1;
    checkOutput({v.name, "_before"}, v.exp_before);
    @(posedge clk);
    #1;
    checkOutput({v.name, "_after"}, v.exp_after);
  endtask

  initial begin
    logic [31:0] oor_read;
    logic [31:0] oor_after;
    logic [31:0] w12_after;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        wr;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 32'd12, 32'h0);

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    oor_read  = 32'd0;
    oor_after = 32'd0;
    w12_after = 32'd3;
`else
    oor_read  = 32'd3;
    oor_after = 32'd7;
    w12_after = 32'd7;
`endif

    vecs.push_back('{"preload12",  1'b0, 32'd12,       32'h0,         32'd3,         32'd3});
    vecs.push_back('{"preload20",  1'b0, 32'd20,       32'h0,         32'd5,         32'd5});
    vecs.push_back('{"write20",    1'b1, 32'd20,       32'h0,         32'd5,         32'd0});
    vecs.push_back('{"hold20",     1'b0, 32'd20,       32'hFFFF_FFFF, 32'd0,         32'd0});
    vecs.push_back('{"write8",     1'b1, 32'd8,        32'hDEAD_BEEF, 32'd2,         32'hDEAD_BEEF});
    vecs.push_back('{"mis9",       1'b0, 32'd9,        32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF});
    vecs.push_back('{"mis10",      1'b0, 32'd10,       32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF});
    vecs.push_back('{"mis11",      1'b0, 32'd11,       32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF});
    vecs.push_back('{"still12",    1'b0, 32'd12,       32'h0,         32'd3,         32'd3});
    vecs.push_back('{"lww_first",  1'b1, 32'd0,        32'd10,        32'd0,         32'd10});
    vecs.push_back('{"lww_second", 1'b1, 32'd0,        32'd11,        32'd10,        32'd11});
    vecs.push_back('{"oor_read",   1'b0, 32'd268,      32'h0,         oor_read,      oor_read});
    vecs.push_back('{"oor_write",  1'b1, 32'd268,      32'd7,         oor_read,      oor_after});
    vecs.push_back('{"word3_12",   1'b0, 32'd12,       32'h0,         w12_after,     w12_after});

    // Reset state, checked while reset is still held.
    #12;
    checkOutput("reset_word3", 32'd3);
    address = 32'd252;
    #1;
    checkOutput("reset_word63", 32'd63);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Asynchronous reset mid-operation, with a write attempted while it is held.
    @(negedge clk);
    applyStimulus(1'b1, 32'd4, 32'h1234);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_write4", 32'h1234);
    applyStimulus(1'b0, 32'd4, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_word1", 32'd1);
    applyStimulus(1'b1, 32'd4, 32'h99);
    @(posedge clk);
    #1;
    checkOutput("write_during_reset", 32'd1);
    address = 32'd20;
    #1;
    checkOutput("reset_restores20", 32'd5);
    @(negedge clk);
    applyStimulus(1'b0, 32'd4, 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("after_release4", 32'd1);

    // Randomized traffic against the reference model.
    model_reset();
    for (int n = 0; n < 400; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) addr = $urandom();
      else addr = 32'($urandom_range(0, DEPTH * 4 - 1));
      wd = $urandom();
      @(negedge clk);
      applyStimulus(wr, addr, wd);
      #1;
      exp = model_read(addr);
      checkOutput("rand_before", exp);
      @(posedge clk);
      if (wr && model_in_range(addr)) model[model_index(addr)] = wd;
      #1;
      exp = model_read(addr);
      checkOutput("rand_after", exp);
    end

    // Sweep all words once to catch any stray corruption.
    @(negedge clk);
    write = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      address = 32'(i * 4);
      #1;
      checkOutput("sweep", model[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
